// File: rtl/mem_copy_pkg.sv
// Shared types for the memory copy engine: FSM state encoding,
// default widths and the address/data typedefs.
package mem_copy_pkg;

  localparam int W_DEF = 8;
  localparam int A_DEF = 8;

  typedef logic [A_DEF-1:0] addr_t;
  typedef logic [W_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_ptr.sv
// Loadable A-bit address pointer with increment enable.
// Wraps modulo 2**A naturally through unsigned overflow.
module mem_copy_ptr #(
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [A-1:0] load_val,
  input  logic         inc,
  output logic [A-1:0] ptr
);

  localparam logic [A-1:0] PTR_ONE = {{(A-1){1'b0}}, 1'b1};

  // Reset wins, then load, then increment.
  always_ff @(posedge Clk) begin
    if (Reset)     ptr <= '0;
    else if (load) ptr <= load_val;
    else if (inc)  ptr <= ptr + PTR_ONE;
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Memory copy engine: copies Len bytes from SrcAddr to DstAddr one byte
// at a time (READ cycle, then WRITE cycle), ascending addresses, wrapping.
// Optional feature macro: CHECKSUM_EN adds a Checksum output holding the
// modulo-2**W sum of the bytes written by the current copy.
//
// Handshake: Start is a single-cycle request, accepted only when the FSM
// is IDLE; Busy is high while bytes are being moved (READ/WRITE) and Done
// pulses for exactly one cycle afterwards. Start at any other time is dropped.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int A = A_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A:0]   Len,
  output logic [A-1:0] MemRdAddr,
  input  logic [W-1:0] MemRdData,
  output logic [A-1:0] MemWrAddr,
  output logic [W-1:0] MemWrData,
  output logic         MemWriteEn,
  output logic         Busy,
  output logic         Done,
`ifdef CHECKSUM_EN
  output logic [W-1:0] Checksum,
`endif
  output state_t       DbgState
);

  localparam logic [A:0] CNT_ONE = {{A{1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [A:0]   cnt_q;
  logic [W-1:0] hold_q;
  logic [A-1:0] rd_addr_q;
  logic [A-1:0] src_ptr, dst_ptr;
  logic         start_ok;
  logic         in_read, in_write;

  assign start_ok = (state_q == IDLE) && Start;
  assign in_read  = (state_q == READ);
  assign in_write = (state_q == WRITE);

  mem_copy_ptr #(.A(A)) u_src_ptr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (start_ok),
    .load_val (SrcAddr),
    .inc      (in_read),
    .ptr      (src_ptr)
  );

  mem_copy_ptr #(.A(A)) u_dst_ptr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (start_ok),
    .load_val (DstAddr),
    .inc      (in_write),
    .ptr      (dst_ptr)
  );

  // Next-state logic; a count of 1 in WRITE means the last byte is going out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = (Len == '0) ? FIN : READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = (cnt_q == CNT_ONE) ? FIN : READ;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, byte count, read-data hold and last read address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok)      cnt_q <= Len;
      else if (in_write) cnt_q <= cnt_q - CNT_ONE;
      if (in_read) begin
        hold_q    <= MemRdData;
        rd_addr_q <= src_ptr;
      end
    end
  end

  // The read address tracks the source pointer only while reading so that
  // it holds the last address used once the copy is over. Reset masks the
  // write strobe so an interrupted copy never writes in the reset cycle.
  assign MemRdAddr  = in_read ? src_ptr : rd_addr_q;
  assign MemWrAddr  = dst_ptr;
  assign MemWrData  = hold_q;
  assign MemWriteEn = in_write && !Reset;
  assign Busy       = in_read || in_write;
  assign Done       = (state_q == FIN);
  assign DbgState   = state_q;

`ifdef CHECKSUM_EN
  logic [W-1:0] sum_q;

  // Running sum of written bytes, restarted by each accepted copy.
  always_ff @(posedge Clk) begin
    if (Reset || start_ok) sum_q <= '0;
    else if (in_write)     sum_q <= sum_q + hold_q;
  end

  assign Checksum = sum_q;
`endif

endmodule
